// File: rtl/sorted_array_writer_pkg.sv
// Shared sizes and FSM state encoding for the insertion-sort RAM writer.
package sorted_writer_pkg;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 8;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_INS,
    S_DONE
  } state_t;
endpackage

// File: rtl/sorted_array_writer_if.sv
// Request side and RAM port of the sorted array writer, bundled in one interface.
interface sorted_array_writer_if;
  import sorted_writer_pkg::*;

  // start is a level request; the value is taken once, in S_IDLE, and done
  // holds until start drops, so a held start never inserts twice.
  logic [DW-1:0] data_i;
  logic          start;
  logic          clear;
  logic          done;
  logic          full;
  logic [AW:0]   count;

  logic [AW-1:0] ram_rdaddr;
  logic [DW-1:0] ram_q;
  logic [AW-1:0] ram_wraddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_wren;

  modport slave (
    input  data_i, start, clear, ram_q,
    output done, full, count, ram_rdaddr, ram_wraddr, ram_wdata, ram_wren
  );

  modport master (
    output data_i, start, clear, ram_q,
    input  done, full, count, ram_rdaddr, ram_wraddr, ram_wdata, ram_wren
  );
endinterface

// File: rtl/sorted_array_writer_datapath.sv
// Holds the value being inserted, the current hole position and the entry count.
module sorted_array_writer_datapath
  import sorted_writer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_data,
  input  logic          shift,
  input  logic          insert,
  input  logic          clear_cnt,
  input  logic [DW-1:0] data_i,
  input  logic [DW-1:0] ram_q,
  output logic [AW:0]   pos_o,
  output logic [AW:0]   count_o,
  output logic [DW-1:0] data_ans_o,
  output logic          q_gt_o
);
  logic [DW-1:0] data_ans_q, data_ans_d;
  logic [AW:0]   pos_q, pos_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    data_ans_d = data_ans_q;
    pos_d      = pos_q;
    count_d    = count_q;
    if (load_data) begin
      data_ans_d = data_i;
      pos_d      = count_q;
    end
    if (shift && pos_q != '0) pos_d = pos_q - ONE_CNT;
    if (insert && count_q != FULL_CNT) count_d = count_q + ONE_CNT;
    // clear wins over any concurrent count change
    if (clear_cnt) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q   <= '0;
      count_q <= '0;
    end else begin
      pos_q   <= pos_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    data_ans_q <= data_ans_d;
  end

  assign pos_o      = pos_q;
  assign count_o    = count_q;
  assign data_ans_o = data_ans_q;
  assign q_gt_o     = ram_q > data_ans_q;
endmodule

// File: rtl/sorted_array_writer.sv
// Insertion-sort writer: shifts larger entries up one slot at a time, then drops
// the new value into the hole so RAM[0..count-1] stays ascending.
module sorted_array_writer
  import sorted_writer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  sorted_array_writer_if.slave bus,
  output state_t               state_o
);
  state_t        state_q, state_d;
  logic          load_data, shift, insert, clear_cnt;
  logic [AW:0]   pos, count;
  logic [DW-1:0] data_ans;
  logic          q_gt;

  sorted_array_writer_datapath u_dp (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .shift      (shift),
    .insert     (insert),
    .clear_cnt  (clear_cnt),
    .data_i     (bus.data_i),
    .ram_q      (bus.ram_q),
    .pos_o      (pos),
    .count_o    (count),
    .data_ans_o (data_ans),
    .q_gt_o     (q_gt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_data      = 1'b0;
    shift          = 1'b0;
    insert         = 1'b0;
    clear_cnt      = 1'b0;
    bus.ram_rdaddr = '0;
    bus.ram_wraddr = '0;
    bus.ram_wdata  = '0;
    bus.ram_wren   = 1'b0;
    bus.done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          clear_cnt = 1'b1;
        end else if (bus.start && !bus.full) begin
          load_data = 1'b1;
          state_d   = (count != '0) ? S_READ : S_INS;
        end
      end
      S_READ: begin
        // pos is at least 1 here and at most DEPTH-1, so the low bits suffice
        bus.ram_rdaddr = pos[AW-1:0] - AW'(1);
        state_d        = S_CMP;
      end
      S_CMP: begin
        if (q_gt) begin
          bus.ram_wren   = 1'b1;
          bus.ram_wraddr = pos[AW-1:0];
          bus.ram_wdata  = bus.ram_q;
          shift          = 1'b1;
          state_d        = (pos == ONE_CNT) ? S_INS : S_READ;
        end else begin
          state_d = S_INS;
        end
      end
      S_INS: begin
        bus.ram_wren   = 1'b1;
        bus.ram_wraddr = pos[AW-1:0];
        bus.ram_wdata  = data_ans;
        insert         = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.clear) clear_cnt = 1'b1;
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.count = count;
  assign bus.full  = (count == FULL_CNT);
  assign state_o   = state_q;
endmodule

// File: tb/tb_sorted_array_writer.sv
// Directed bench for sorted_array_writer with a registered-address RAM model.
module tb_sorted_array_writer;
  import sorted_writer_pkg::*;

  localparam int W = AW + DW;

  logic   clk = 1'b0;
  logic   reset;
  state_t state;
  int     total = 0;
  int     bad   = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [W-1:0]  wr_log[$];
  logic [W-1:0]  exp_q[$];

  sorted_array_writer_if bus ();

  sorted_array_writer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset / RAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_wren) begin
      mem[bus.ram_wraddr] <= bus.ram_wdata;
      wr_log.push_back({bus.ram_wraddr, bus.ram_wdata});
    end
    bus.ram_q <= mem[bus.ram_rdaddr];
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    exp_q.push_back({AW'(a), DW'(d)});
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check({tag, "_wr"}, 32'(wr_log[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // ---------------- drivers ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called and returns on a falling edge; edges counts from the start-sampling edge.
  task automatic do_insert(input logic [DW-1:0] v, input int hold, output int edges);
    wr_log.delete();
    bus.data_i = v;
    bus.start  = 1'b1;
    edges      = 0;
    do begin
      cycle();
      edges++;
    end while (!bus.done && edges < 200);
    check("done_rise", 32'(bus.done), 32'd1);
    for (int i = 0; i < hold; i++) begin
      cycle();
      check("done_hold", 32'(bus.done), 32'd1);
    end
    bus.start = 1'b0;
    cycle();
    check("done_fall", 32'(bus.done), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n;
    int cmp_hits;
    logic [DW-1:0] exp_mem [6];

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.clear  = 1'b0;
    bus.data_i = '0;
    repeat (3) cycle();

    check("rst_count",  32'(bus.count),      32'd0);
    check("rst_state",  32'(state),          32'(S_IDLE));
    check("rst_done",   32'(bus.done),       32'd0);
    check("rst_full",   32'(bus.full),       32'd0);
    check("rst_wren",   32'(bus.ram_wren),   32'd0);
    check("rst_rdaddr", 32'(bus.ram_rdaddr), 32'd0);
    check("rst_wraddr", 32'(bus.ram_wraddr), 32'd0);
    check("rst_wdata",  32'(bus.ram_wdata),  32'd0);
    reset = 1'b0;
    cycle();

    // empty array: one write, held start must not re-insert
    do_insert(8'h40, 3, n);
    check("ins40_edges", 32'(n), 32'd2);
    push_wr(0, 8'h40);
    check_writes("ins40");
    check("ins40_count", 32'(bus.count), 32'd1);

    do_insert(8'h50, 0, n);
    check("ins50_edges", 32'(n), 32'd4);
    push_wr(1, 8'h50);
    check_writes("ins50");

    do_insert(8'h30, 0, n);
    check("ins30_edges", 32'(n), 32'd6);
    push_wr(2, 8'h50); push_wr(1, 8'h40); push_wr(0, 8'h30);
    check_writes("ins30");

    do_insert(8'h10, 0, n);
    check("ins10_edges", 32'(n), 32'd8);
    push_wr(3, 8'h50); push_wr(2, 8'h40); push_wr(1, 8'h30); push_wr(0, 8'h10);
    check_writes("ins10");

    do_insert(8'h20, 0, n);
    check("ins20_edges", 32'(n), 32'd10);
    push_wr(4, 8'h50); push_wr(3, 8'h40); push_wr(2, 8'h30); push_wr(1, 8'h20);
    check_writes("ins20");
    check("five_count", 32'(bus.count), 32'd5);

    // duplicate stops at the equal entry and lands above it
    do_insert(8'h30, 0, n);
    check("dup_edges", 32'(n), 32'd8);
    push_wr(5, 8'h50); push_wr(4, 8'h40); push_wr(3, 8'h30);
    check_writes("dup");
    exp_mem = '{8'h10, 8'h20, 8'h30, 8'h30, 8'h40, 8'h50};
    for (int i = 0; i < 6; i++) check("dup_mem", 32'(mem[i]), 32'(exp_mem[i]));
    check("dup_count", 32'(bus.count), 32'd6);

    // fill to 31 with ascending values, then a minimum that shifts all 31
    for (int i = 0; i < 25; i++) do_insert(8'(8'h60 + i), 0, n);
    check("fill31_count", 32'(bus.count), 32'd31);
    check("fill31_full",  32'(bus.full),  32'd0);
    do_insert(8'h00, 0, n);
    check("all_shift_edges", 32'(n), 32'd64);
    check("all_shift_nwr", 32'(wr_log.size()), 32'd32);
    check("all_shift_first", 32'(wr_log[0]), 32'({5'd31, 8'h78}));
    check("all_shift_last", 32'(wr_log[31]), 32'({5'd0, 8'h00}));
    check("full_count", 32'(bus.count), 32'd32);
    check("full_flag", 32'(bus.full), 32'd1);
    check("full_mem0", 32'(mem[0]), 32'h00);
    check("full_mem4", 32'(mem[4]), 32'h30);
    check("full_mem31", 32'(mem[31]), 32'h78);

    // start while full is ignored
    wr_log.delete();
    bus.data_i = 8'h05;
    bus.start  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rej_done", 32'(bus.done), 32'd0);
      check("rej_state", 32'(state), 32'(S_IDLE));
    end
    bus.start = 1'b0;
    check("rej_nwr", 32'(wr_log.size()), 32'd0);
    check("rej_count", 32'(bus.count), 32'd32);
    check("rej_full", 32'(bus.full), 32'd1);

    // reset during S_CMP of a 4-shift insertion
    pulse_reset();
    for (int i = 1; i <= 4; i++) do_insert(8'(i), 0, n);
    check("pre_rst_count", 32'(bus.count), 32'd4);
    bus.data_i = 8'h00;
    bus.start  = 1'b1;
    cmp_hits   = 0;
    for (int i = 0; i < 100 && cmp_hits < 2; i++) begin
      cycle();
      if (state == S_CMP) cmp_hits++;
    end
    check("midrst_reach_cmp", 32'(cmp_hits), 32'd2);
    reset     = 1'b1;
    bus.start = 1'b0;
    cycle();
    check("midrst_state", 32'(state), 32'(S_IDLE));
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_wren", 32'(bus.ram_wren), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    cycle();

    // clear beats start in S_IDLE
    for (int i = 0; i < 5; i++) do_insert(8'(8'h11 + i), 0, n);
    check("pre_clr_count", 32'(bus.count), 32'd5);
    wr_log.delete();
    bus.data_i = 8'h99;
    bus.start  = 1'b1;
    bus.clear  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("clr_state", 32'(state), 32'(S_IDLE));
    end
    bus.start = 1'b0;
    bus.clear = 1'b0;
    check("clr_count", 32'(bus.count), 32'd0);
    check("clr_nwr", 32'(wr_log.size()), 32'd0);
    cycle();
    do_insert(8'h77, 0, n);
    check("post_clr_edges", 32'(n), 32'd2);
    push_wr(0, 8'h77);
    check_writes("post_clr");
    check("post_clr_count", 32'(bus.count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
